// File: rtl/eig_watch.sv
// rtl/eig_watch.sv - eigen-distance watchdog: regime/threshold persistence, sticky alarm, 6-byte event frames
module eig_watch #(
  parameter logic [7:0] FRAME_HDR = 8'hA5,
  parameter int         PERSIST_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 res_valid,
  input  logic [31:0]          kappa,
  input  logic [31:0]          inv_kappa,
  input  logic [2:0]           regime,
  input  logic [31:0]          kappa_th,
  input  logic [PERSIST_W-1:0] persist,
  input  logic                 clr_alarm,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic                 alarm,
  output logic [1:0]           alarm_code,
  output logic [2:0]           regime_stable,
  output logic [31:0]          kappa_last,
  output logic [7:0]           err_cnt,
  output logic [7:0]           drop_cnt
);

  localparam logic [PERSIST_W-1:0] CNT_MAX = '1;
  localparam logic [PERSIST_W-1:0] CNT_ONE = PERSIST_W'(1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_t;

  tx_state_t            state_q, state_d;

  logic [2:0]           prev_regime;
  logic [PERSIST_W-1:0] run_cnt, th_cnt;
  logic [PERSIST_W-1:0] run_next, th_next, eff_persist;
  logic [31:0]          kappa_abs;
  logic                 acc, acc_ok, onehot, th_hit, reg_ev, th_ev;
  logic [1:0]           code;

  // Event produced by the previous accept, consumed by the frame logic
  logic                 ev_valid;
  logic [1:0]           ev_code;

  // Frame being sent and the one-deep pending frame
  logic [2:0]           idx;
  logic [1:0]           act_code, pend_code;
  logic [2:0]           act_regime, pend_regime;
  logic [31:0]          act_kappa, pend_kappa;
  logic                 pend_valid;
  logic                 hs, last_hs, load;

  // inv_kappa travels with the result but nothing here evaluates it
  logic                 unused_inv;
  assign unused_inv = ^inv_kappa;

  // Result classification, magnitude and run-length lookahead
  always_comb begin
    acc         = ena & res_valid;
    onehot      = (regime == 3'b001) || (regime == 3'b010) || (regime == 3'b100);
    acc_ok      = acc & onehot;
    eff_persist = (persist == '0) ? CNT_ONE : persist;
    if (!kappa[31])
      kappa_abs = kappa;
    else if (kappa == 32'h8000_0000)
      kappa_abs = 32'h7FFF_FFFF;
    else
      kappa_abs = ~kappa + 32'd1;
    if (regime == prev_regime)
      run_next = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;
    else
      run_next = CNT_ONE;
    th_hit  = (kappa_abs >= kappa_th);
    if (th_hit)
      th_next = (th_cnt == CNT_MAX) ? th_cnt : th_cnt + CNT_ONE;
    else
      th_next = '0;
    reg_ev = (run_next >= eff_persist) && (regime != regime_stable);
    // Fires only on the transition into eff_persist, so a saturated run stays quiet
    th_ev  = th_hit && (th_next == eff_persist) && (th_cnt != eff_persist);
    code   = acc_ok ? {reg_ev, th_ev} : 2'b00;
  end

  // Result bookkeeping, counters and sticky alarm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kappa_last    <= '0;
      err_cnt       <= '0;
      prev_regime   <= '0;
      run_cnt       <= '0;
      th_cnt        <= '0;
      regime_stable <= '0;
      alarm         <= 1'b0;
      alarm_code    <= '0;
      ev_valid      <= 1'b0;
      ev_code       <= '0;
    end else if (ena) begin
      if (acc)
        kappa_last <= kappa;
      if (acc && !onehot && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      if (acc_ok) begin
        prev_regime <= regime;
        run_cnt     <= run_next;
        th_cnt      <= th_next;
        if (code[1])
          regime_stable <= regime;
      end
      if (code != 2'b00) begin
        alarm      <= 1'b1;
        alarm_code <= clr_alarm ? code : (alarm_code | code);
      end else if (clr_alarm) begin
        alarm      <= 1'b0;
        alarm_code <= '0;
      end
      ev_valid <= (code != 2'b00);
      ev_code  <= code;
    end
  end

  assign hs      = tx_valid & tx_ready;
  assign last_hs = hs && (idx == 3'd5);
  assign load    = (state_q == IDLE) || last_hs;

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else if (ena)
      state_q <= state_d;
  end

  // TX next state: leave IDLE on any frame source, return only when nothing is queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ev_valid || pend_valid) state_d = SEND;
      SEND: if (last_hs && !(ev_valid || pend_valid)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // TX outputs: byte mux over the captured frame
  always_comb begin
    tx_valid = (state_q == SEND);
    tx_data  = 8'h00;
    if (state_q == SEND) begin
      case (idx)
        3'd0:    tx_data = FRAME_HDR;
        3'd1:    tx_data = {act_code, 3'b000, act_regime};
        3'd2:    tx_data = act_kappa[31:24];
        3'd3:    tx_data = act_kappa[23:16];
        3'd4:    tx_data = act_kappa[15:8];
        default: tx_data = act_kappa[7:0];
      endcase
    end
  end

  // Frame capture, byte index, pending buffer and drop counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      act_code    <= '0;
      act_regime  <= '0;
      act_kappa   <= '0;
      pend_valid  <= 1'b0;
      pend_code   <= '0;
      pend_regime <= '0;
      pend_kappa  <= '0;
      drop_cnt    <= '0;
    end else if (ena) begin
      if (load) begin
        idx <= '0;
        if (pend_valid) begin
          act_code   <= pend_code;
          act_regime <= pend_regime;
          act_kappa  <= pend_kappa;
          pend_valid <= ev_valid;
          if (ev_valid) begin
            pend_code   <= ev_code;
            pend_regime <= regime_stable;
            pend_kappa  <= kappa_last;
          end
        end else if (ev_valid) begin
          act_code   <= ev_code;
          act_regime <= regime_stable;
          act_kappa  <= kappa_last;
        end
      end else begin
        if (hs)
          idx <= idx + 3'd1;
        if (ev_valid) begin
          if (!pend_valid) begin
            pend_valid  <= 1'b1;
            pend_code   <= ev_code;
            pend_regime <= regime_stable;
            pend_kappa  <= kappa_last;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eig_watch.sv
// tb/tb_eig_watch.sv - vector table plus frame scoreboard for eig_watch
module tb_eig_watch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] kappa = '0;
  logic [31:0] inv_kappa = '0;
  logic [2:0]  regime = '0;
  logic [31:0] kappa_th = 32'h7FFF_FFFF;
  logic [3:0]  persist = 4'd1;
  logic        clr_alarm = 1'b0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        alarm;
  logic [1:0]  alarm_code;
  logic [2:0]  regime_stable;
  logic [31:0] kappa_last;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  logic [7:0] exp_q[$];

  eig_watch #(.FRAME_HDR(8'hA5), .PERSIST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .res_valid(res_valid),
    .kappa(kappa), .inv_kappa(inv_kappa), .regime(regime), .kappa_th(kappa_th),
    .persist(persist), .clr_alarm(clr_alarm), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .alarm(alarm), .alarm_code(alarm_code),
    .regime_stable(regime_stable), .kappa_last(kappa_last),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  persist;
    logic [31:0] th;
    logic [2:0]  regime;
    logic [31:0] kappa;
    logic        clr;
    logic [1:0]  ev;
    logic [1:0]  code;
    logic [2:0]  stable;
    logic [7:0]  err;
  } vec_t;

  vec_t tbl [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] c, input logic [2:0] r, input logic [31:0] k);
    exp_q.push_back(8'hA5);
    exp_q.push_back({c, 3'b000, r});
    exp_q.push_back(k[31:24]);
    exp_q.push_back(k[23:16]);
    exp_q.push_back(k[15:8]);
    exp_q.push_back(k[7:0]);
  endtask

  task automatic accept(input logic [2:0] r, input logic [31:0] k, input logic c);
    @(posedge clk); #1;
    res_valid = 1'b1; regime = r; kappa = k; inv_kappa = ~k; clr_alarm = c;
    @(posedge clk); #1;
    res_valid = 1'b0; clr_alarm = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !tx_valid) return;
    end
    tests++; fails++;
    $display("FAIL drain_timeout actual=%0d bytes left expected=0", exp_q.size());
  endtask

  // Scoreboard: every handshaken byte must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && ena && tx_valid && tx_ready) begin
      hs_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_byte actual=%h expected=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL tx_byte actual=%h expected=%h", tx_data, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] held;
    //            persist th             regime  kappa          clr   ev     code   stable  err
    tbl[0]  = '{4'd3, 32'h7FFF_FFFF, 3'b001, 32'h0001_0000, 1'b0, 2'd0, 2'd0, 3'b000, 8'd0};
    tbl[1]  = '{4'd3, 32'h7FFF_FFFF, 3'b001, 32'h0001_0000, 1'b0, 2'd0, 2'd0, 3'b000, 8'd0};
    tbl[2]  = '{4'd3, 32'h7FFF_FFFF, 3'b001, 32'h0001_0000, 1'b0, 2'd2, 2'd2, 3'b001, 8'd0};
    tbl[3]  = '{4'd2, 32'h0002_0000, 3'b010, 32'hFFFD_0000, 1'b0, 2'd0, 2'd2, 3'b001, 8'd0};
    tbl[4]  = '{4'd2, 32'h0002_0000, 3'b010, 32'h0003_0000, 1'b0, 2'd3, 2'd3, 3'b010, 8'd0};
    tbl[5]  = '{4'd2, 32'h0002_0000, 3'b011, 32'h0000_1234, 1'b0, 2'd0, 2'd3, 3'b010, 8'd1};
    tbl[6]  = '{4'd1, 32'h7FFF_FFFF, 3'b010, 32'h0000_0000, 1'b1, 2'd0, 2'd0, 3'b010, 8'd1};
    tbl[7]  = '{4'd1, 32'h8000_0000, 3'b010, 32'h8000_0000, 1'b0, 2'd0, 2'd0, 3'b010, 8'd1};
    tbl[8]  = '{4'd1, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 1'b0, 2'd1, 2'd1, 3'b010, 8'd1};
    tbl[9]  = '{4'd0, 32'h7FFF_FFFF, 3'b100, 32'h0000_0005, 1'b1, 2'd2, 2'd2, 3'b100, 8'd1};
    tbl[10] = '{4'd1, 32'h7FFF_FFFF, 3'b100, 32'h8000_0000, 1'b0, 2'd1, 2'd3, 3'b100, 8'd1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_alarm_code", 32'(alarm_code), 32'd0);
    check("rst_regime_stable", 32'(regime_stable), 32'd0);
    check("rst_kappa_last", kappa_last, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table: one accept per row, frame drained before the status checks
    for (int i = 0; i < 11; i++) begin
      persist  = tbl[i].persist;
      kappa_th = tbl[i].th;
      if (tbl[i].ev != 2'd0) push_frame(tbl[i].ev, tbl[i].stable, tbl[i].kappa);
      accept(tbl[i].regime, tbl[i].kappa, tbl[i].clr);
      drain();
      check($sformatf("row%0d_alarm", i), 32'(alarm), 32'(tbl[i].code != 2'd0));
      check($sformatf("row%0d_alarm_code", i), 32'(alarm_code), 32'(tbl[i].code));
      check($sformatf("row%0d_regime_stable", i), 32'(regime_stable), 32'(tbl[i].stable));
      check($sformatf("row%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].err));
      check($sformatf("row%0d_kappa_last", i), kappa_last, tbl[i].kappa);
    end

    // Latency: header two cycles after the accept edge
    persist = 4'd1; kappa_th = 32'h7FFF_FFFF;
    push_frame(2'd2, 3'b001, 32'h0);
    accept(3'b001, 32'h0, 1'b0);
    @(negedge clk);
    check("lat_cycle1_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_tx_valid", 32'(tx_valid), 32'd1);
    check("lat_cycle2_tx_data", 32'(tx_data), 32'hA5);
    drain();

    // Backpressure: one frame stalled, one pending, one dropped
    tx_ready = 1'b0;
    push_frame(2'd2, 3'b010, 32'h11);
    accept(3'b010, 32'h11, 1'b0);
    push_frame(2'd2, 3'b100, 32'h22);
    accept(3'b100, 32'h22, 1'b0);
    accept(3'b001, 32'h33, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_tx_valid", 32'(tx_valid), 32'd1);
      check("stall_tx_data", 32'(tx_data), 32'hA5);
    end
    check("stall_drop_cnt", 32'(drop_cnt), 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    drain();
    check("stall_regime_stable", 32'(regime_stable), 32'b001);

    // Disabled accept is ignored
    ena = 1'b0;
    accept(3'b010, 32'h99, 1'b0);
    @(posedge clk); #1;
    ena = 1'b1;
    drain();
    check("ena0_kappa_last", kappa_last, 32'h33);
    check("ena0_regime_stable", 32'(regime_stable), 32'b001);

    // clr_alarm alone
    @(posedge clk); #1; clr_alarm = 1'b1;
    @(posedge clk); #1; clr_alarm = 1'b0;
    @(negedge clk);
    check("clr_alarm", 32'(alarm), 32'd0);
    check("clr_alarm_code", 32'(alarm_code), 32'd0);

    // Reset while byte 3 is on the bus
    push_frame(2'd2, 3'b010, 32'h0A0B_0C0D);
    base = hs_cnt;
    accept(3'b010, 32'h0A0B_0C0D, 1'b0);
    for (int c = 0; c < 50 && hs_cnt < base + 3; c++) @(posedge clk);
    check("abort_bytes_before_reset", hs_cnt - base, 32'd3);
    #1;
    held = tx_data;
    check("abort_byte3_visible", 32'(held), 32'h0B);
    rst_n = 1'b0;
    #1;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_alarm", 32'(alarm), 32'd0);
    check("abort_regime_stable", 32'(regime_stable), 32'd0);
    check("abort_kappa_last", kappa_last, 32'd0);
    check("abort_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    base = hs_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_resume", hs_cnt - base, 32'd0);
    check("abort_idle_tx_valid", 32'(tx_valid), 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eig_watch.md
EIG_WATCH -- requirements
Module: eig_watch

Interface
REQ-001 Parameter FRAME_HDR, default 8'hA5: first byte of every transmitted event frame.
REQ-002 Parameter PERSIST_W, default 4: width of persist input and run counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ena  in  1  global enable; low freezes all state.
REQ-006 res_valid  in  1  single-cycle pulse; kappa/inv_kappa/regime valid this cycle.
REQ-007 kappa  in  32  signed Q16.16 eigen-distance from the eigen core.
REQ-008 inv_kappa  in  32  signed Q16.16 reciprocal; carried, not evaluated.
REQ-009 regime  in  3  one-hot: 001 underdamped, 010 critical, 100 overdamped.
REQ-010 kappa_th  in  32  unsigned Q16.16 alarm threshold on |kappa|.
REQ-011 persist  in  PERSIST_W  consecutive-result count required to declare a condition; 0 treated as 1.
REQ-012 clr_alarm  in  1  clears sticky alarm.
REQ-013 tx_ready  in  1  downstream byte sink ready.
REQ-014 tx_valid  out  1  byte available on tx_data.
REQ-015 tx_data  out  8  frame byte.
REQ-016 alarm  out  1  sticky alarm flag.
REQ-017 alarm_code  out  2  bit0 threshold event, bit1 regime-change event; sticky OR of causes.
REQ-018 regime_stable  out  3  last regime held for persist consecutive results.
REQ-019 kappa_last  out  32  kappa of last accepted result.
REQ-020 err_cnt  out  8  saturating count of results with non-one-hot regime.
REQ-021 drop_cnt  out  8  saturating count of events lost to a full pending buffer.

Function
REQ-022 A result is accepted only when ena=1 and res_valid=1; accept updates kappa_last.
REQ-023 Result with regime not in {001,010,100}: err_cnt+1 (saturate 255); run counters unchanged; no event; kappa_last still updates.
REQ-024 Regime run: same regime as previous accepted result -> run_cnt+1 saturating at 2^PERSIST_W-1; else run_cnt=1.
REQ-025 When run_cnt reaches effective persist and regime differs from regime_stable, regime_stable updates next cycle and a regime event (code bit1) is raised; first stabilisation after reset (regime_stable=000) also raises it.
REQ-026 |kappa| computed as two's-complement magnitude; 32'h8000_0000 maps to 32'h7FFF_FFFF.
REQ-027 Threshold run: |kappa| >= kappa_th increments th_cnt (saturating), else th_cnt=0; threshold event raised exactly once on the cycle th_cnt reaches effective persist, re-armed after th_cnt returns to 0.
REQ-028 Both events in the same accept produce one event with code 2'b11.
REQ-029 On any event: alarm<=1, alarm_code<=alarm_code|code, one cycle after the accept.
REQ-030 clr_alarm=1 clears alarm and alarm_code; a simultaneous event wins (alarm=1, alarm_code=new code only).
REQ-031 Frame = 6 bytes: FRAME_HDR, {code[1:0],3'b000,regime_stable}, kappa_last[31:24], [23:16], [15:8], [7:0]; fields captured at event time.
REQ-032 TX FSM states IDLE, SEND; IDLE->SEND when an event or pending frame exists; SEND holds byte index 0..5; index advances on tx_valid&tx_ready; after byte 5 handshake -> IDLE, or directly reload pending frame (no idle cycle).
REQ-033 tx_valid asserted in SEND only; tx_data stable while tx_valid=1 and tx_ready=0.
REQ-034 Event while IDLE starts sending next cycle; event while SEND stores in one-deep pending buffer; event with pending full is dropped, drop_cnt+1 (saturate 255).
REQ-035 ena=0: no acceptance, FSM and index hold, tx_valid held at current value, no counters change.
REQ-036 Latency: accept -> tx_valid with header = 2 cycles when IDLE.

Reset
REQ-037 rst_n low: FSM IDLE, tx_valid=0, tx_data=0, alarm=0, alarm_code=0, regime_stable=000, kappa_last=0, run/th counters 0, pending empty, err_cnt=0, drop_cnt=0.
REQ-038 Reset mid-frame aborts the frame; no byte resumes after release.

Verification
REQ-039 persist=3, three results regime=001, kappa=0x0001_0000, kappa_th=0x7FFF_FFFF, tx_ready=1 -> regime_stable=001, alarm=1, alarm_code=10, frame A5,81,00,01,00,00.
REQ-040 kappa_th=0x0002_0000, persist=2, kappas -0x0003_0000, 0x0003_0000, regime 010 each -> threshold and regime both on 2nd accept, single frame with byte1=C2.
REQ-041 tx_ready=0 for 10 cycles during SEND, three further events -> tx_data stable, one pending frame sent after, drop_cnt=1.
REQ-042 regime=011 accepted -> err_cnt=1, no frame, regime_stable unchanged.
REQ-043 clr_alarm asserted same cycle as an event -> alarm=1 with only the new code; clr_alarm alone -> alarm=0, alarm_code=00.
REQ-044 rst_n pulsed low at byte 3 of a frame -> tx_valid=0 immediately, all outputs at reset values, no bytes after release.
